bcd_convert_scheduler: RTL and testbench

Shares one iterative binary-to-BCD conversion engine among several requesters: score, lines cleared, level and high score.
- Arbitrates round-robin and accepts one binary word per grant.
- Runs double-dabble at one shift/adjust step per clock.
- Returns the decimal digits tagged with the requester ID over a valid/ready result channel.
- Sits between game-state counters and the seven-segment/VGA digit renderers.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_dabble_engine.sv | 67 ++++++
 rtl/bcd_convert_scheduler.sv | 126 ++++++++++++
 tb/tb_bcd_convert_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD conversion scheduler.
//   state_t        : scheduler FSM states
//   DIGIT_W        : bits per BCD digit
//   ADD3_THRESHOLD : nibble value at or above which double-dabble adds 3
//   ADD3_VALUE     : correction added to such nibbles
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    DONE
  } state_t;

  localparam int unsigned DIGIT_W        = 4;
  localparam int unsigned ADD3_THRESHOLD = 5;
  localparam int unsigned ADD3_VALUE     = 3;

endpackage

// File: rtl/bcd_dabble_engine.sv
// Iterative double-dabble binary-to-BCD datapath, one adjust/shift step per clock.
//   clk, reset   : clock, asynchronous active-high reset
//   i_load       : load i_load_data into the binary register, clear BCD and step count
//   i_step       : perform one adjust+shift step (ignored once all steps are done)
//   i_load_data  : binary value to convert
//   o_digits     : current BCD register, ones digit in bits [3:0]
//   o_last       : the step issued this cycle is the final one
//   o_done       : all DATA_W steps have been performed
module bcd_dabble_engine
  import bcd_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_DIGITS = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_load,
  input  logic                          i_step,
  input  logic [DATA_W-1:0]             i_load_data,
  output logic [NUM_DIGITS*DIGIT_W-1:0] o_digits,
  output logic                          o_last,
  output logic                          o_done
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam int unsigned BCD_W = NUM_DIGITS * DIGIT_W;

  logic [DATA_W-1:0] r_bin;
  logic [BCD_W-1:0]  r_bcd;
  logic [CNT_W-1:0]  r_cnt;

  logic [BCD_W-1:0]  w_adj;
  logic [BCD_W-1:0]  w_bcd_nxt;
  logic [DATA_W-1:0] w_bin_nxt;

  // Add-3 correction on every nibble, then shift the whole {bcd, bin} vector left by one.
  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (r_bcd[d*DIGIT_W +: DIGIT_W] >= DIGIT_W'(ADD3_THRESHOLD)) begin
        w_adj[d*DIGIT_W +: DIGIT_W] = r_bcd[d*DIGIT_W +: DIGIT_W] + DIGIT_W'(ADD3_VALUE);
      end
    end
    {w_bcd_nxt, w_bin_nxt} = {w_adj, r_bin} << 1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_bin <= i_load_data;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (i_step && !o_done) begin
      r_bin <= w_bin_nxt;
      r_bcd <= w_bcd_nxt;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_digits = r_bcd;
  assign o_last   = (r_cnt == CNT_W'(DATA_W - 1));
  assign o_done   = (r_cnt == CNT_W'(DATA_W));

endmodule

// File: rtl/bcd_convert_scheduler.sv
// Round-robin scheduler sharing one double-dabble engine among NUM_REQ requesters.
//   clk, reset  : clock, asynchronous active-high reset
//   req_valid   : per-requester conversion request
//   req_data    : per-requester binary value, requester i at [i*DATA_W +: DATA_W]
//   req_ready   : one-hot grant, combinational in IDLE
//   res_valid   : result available (DONE state)
//   res_ready   : consumer accepts result
//   res_id      : requester that owns the result
//   res_digits  : BCD digits, ones in [3:0]; holds the last accepted result outside DONE
//   busy        : scheduler is converting or holding a result
module bcd_convert_scheduler
  import bcd_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_DIGITS = 10,
  parameter int unsigned ID_W       = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [ID_W-1:0]               res_id,
  output logic [NUM_DIGITS*DIGIT_W-1:0] res_digits,
  output logic                          busy
);

  localparam int unsigned BCD_W = NUM_DIGITS * DIGIT_W;

  state_t            r_state, w_state_nxt;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_id;
  logic [BCD_W-1:0]  r_hold;

  logic              w_found;
  logic [ID_W-1:0]   w_gnt;
  logic [ID_W-1:0]   w_sel;
  int unsigned       w_idx;
  logic              w_load;
  logic              w_step;
  logic [BCD_W-1:0]  w_eng_digits;
  logic              w_eng_last;
  logic              w_eng_done;

  // Scan offsets from farthest to nearest so the requester closest to the pointer wins.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = 0;
    w_sel   = '0;
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      w_idx = (32'(r_ptr) + k - 1) % NUM_REQ;
      w_sel = ID_W'(w_idx);
      if (req_valid[w_sel]) begin
        w_found = 1'b1;
        w_gnt   = w_sel;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    req_ready   = '0;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          req_ready[w_gnt] = 1'b1;
          w_load           = 1'b1;
          w_state_nxt      = CONVERT;
        end
      end
      CONVERT: begin
        w_step = 1'b1;
        // Leave on the edge that performs the final step so the result is ready on DONE entry.
        if (w_eng_last) w_state_nxt = DONE;
      end
      DONE: begin
        if (res_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_id    <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_id  <= w_gnt;
        r_ptr <= ID_W'((32'(w_gnt) + 1) % NUM_REQ);
      end
      if (r_state == DONE && res_ready) r_hold <= w_eng_digits;
    end
  end

  bcd_dabble_engine #(
    .DATA_W     (DATA_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_engine (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_load),
    .i_step      (w_step),
    .i_load_data (req_data[w_gnt*DATA_W +: DATA_W]),
    .o_digits    (w_eng_digits),
    .o_last      (w_eng_last),
    .o_done      (w_eng_done)
  );

  // The engine is idle in DONE, so its register is the stable result there; elsewhere the
  // last accepted result is shown.
  assign res_valid  = (r_state == DONE);
  assign res_id     = r_id;
  assign res_digits = (r_state == DONE && w_eng_done) ? w_eng_digits : r_hold;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_bcd_convert_scheduler.sv
module tb_bcd_convert_scheduler;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int NDIG    = 10;
  localparam int ID_W    = 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    res_valid;
  logic                    res_ready;
  logic [ID_W-1:0]         res_id;
  logic [NDIG*4-1:0]       res_digits;
  logic                    busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  bcd_convert_scheduler #(
    .NUM_REQ    (NUM_REQ),
    .DATA_W     (DATA_W),
    .NUM_DIGITS (NDIG),
    .ID_W       (ID_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_id     (res_id),
    .res_digits (res_digits),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Decimal digits by repeated division.
  function automatic logic [NDIG*4-1:0] to_bcd(input logic [DATA_W-1:0] v);
    longint unsigned x;
    logic [NDIG*4-1:0] r;
    x = longint'(v);
    r = '0;
    for (int i = 0; i < NDIG; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Logs of observed DUT events for the directed literal checks.
  int              g_ids[$];
  int              g_cyc[$];
  int              r_ids[$];
  logic [NDIG*4-1:0] r_dig[$];
  int              r_cyc[$];

  // Behavioural model: a grant starts a job; result visible DATA_W+1 cycles later until
  // accepted; pointer is one past the last grant.
  logic              m_pending = 1'b0;
  int                m_timer   = 0;
  int                m_ptr     = 0;
  int                m_id      = 0;
  logic [NDIG*4-1:0] m_dig     = '0;
  logic [NDIG*4-1:0] m_last    = '0;
  logic              e_found;
  int                e_g;
  logic [NUM_REQ-1:0] e_rr;
  logic              e_rv;
  logic [NDIG*4-1:0] e_dig;
  logic              prev_rv = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      e_found = 1'b0;
      e_g     = 0;
      e_rr    = '0;
      e_rv    = 1'b0;
      e_dig   = '0;
      if (reset) begin
        chk("rst_req_ready", req_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_digits", res_digits, 0);
        prev_rv = 1'b0;
      end else begin
        if (!m_pending) begin
          for (int k = NUM_REQ; k > 0; k--) begin
            if (req_valid[(m_ptr + k - 1) % NUM_REQ]) begin
              e_found = 1'b1;
              e_g     = (m_ptr + k - 1) % NUM_REQ;
            end
          end
        end
        if (e_found) e_rr[e_g] = 1'b1;
        e_rv  = m_pending && (m_timer >= DATA_W + 1);
        e_dig = e_rv ? m_dig : m_last;
        chk("req_ready", req_ready, e_rr);
        chk("res_valid", res_valid, e_rv);
        chk("busy", busy, m_pending);
        chk("res_digits", res_digits, e_dig);
        if (e_rv) chk("res_id", res_id, m_id);
        for (int i = 0; i < NUM_REQ; i++) begin
          if (req_ready[i]) begin
            g_ids.push_back(i);
            g_cyc.push_back(cyc);
          end
        end
        if (res_valid && !prev_rv) begin
          r_ids.push_back(int'(res_id));
          r_dig.push_back(res_digits);
          r_cyc.push_back(cyc);
        end
        prev_rv = res_valid;
        if (e_found) m_dig = to_bcd(req_data[e_g*DATA_W +: DATA_W]);
      end
      @(posedge clk);
      cyc++;
      if (reset) begin
        m_pending = 1'b0;
        m_ptr     = 0;
        m_id      = 0;
        m_last    = '0;
      end else if (e_found) begin
        m_pending = 1'b1;
        m_timer   = 1;
        m_id      = e_g;
        m_ptr     = (e_g + 1) % NUM_REQ;
      end else if (m_pending) begin
        if (e_rv && res_ready) begin
          m_pending = 1'b0;
          m_last    = m_dig;
        end else begin
          m_timer++;
        end
      end
    end
  end

  // Requesters drop req_valid the cycle after they are granted.
  task automatic run_cycles(input int n);
    logic [NUM_REQ-1:0] seen;
    repeat (n) begin
      @(negedge clk);
      seen = req_valid & req_ready;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~seen;
    end
  endtask

  task automatic wait_results(input int n, input int max);
    int t = 0;
    while (r_ids.size() < n && t < max) begin
      run_cycles(1);
      t++;
    end
    if (r_ids.size() < n) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_results timeout actual=%0d required=%0d", r_ids.size(), n);
    end
  endtask

  task automatic wait_grants(input int n, input int max);
    int t = 0;
    while (g_ids.size() < n && t < max) begin
      run_cycles(1);
      t++;
    end
    if (g_ids.size() < n) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_grants timeout actual=%0d required=%0d", g_ids.size(), n);
    end
  endtask

  task automatic clear_logs();
    g_ids.delete(); g_cyc.delete(); r_ids.delete(); r_dig.delete(); r_cyc.delete();
  endtask

  task automatic set_lane(input int i, input logic [DATA_W-1:0] v);
    req_data[i*DATA_W +: DATA_W] = v;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    run_cycles(2);

    // Four requesters at once: grants 0,1,2,3 spaced DATA_W+2 apart.
    clear_logs();
    set_lane(0, 11); set_lane(1, 22); set_lane(2, 33); set_lane(3, 44);
    req_valid = 4'hF;
    wait_results(4, 400);
    run_cycles(2);
    if (g_ids.size() == 4 && r_ids.size() == 4) begin
      chk("rr_order", {g_ids[3][7:0], g_ids[2][7:0], g_ids[1][7:0], g_ids[0][7:0]},
          64'h03020100);
      for (int i = 1; i < 4; i++) chk("rr_interval", g_cyc[i] - g_cyc[i-1], DATA_W + 2);
      chk("rr_dig0", r_dig[0], 40'h11);
      chk("rr_dig1", r_dig[1], 40'h22);
      chk("rr_dig2", r_dig[2], 40'h33);
      chk("rr_dig3", r_dig[3], 40'h44);
      chk("rr_ids", {r_ids[3][7:0], r_ids[2][7:0], r_ids[1][7:0], r_ids[0][7:0]},
          64'h03020100);
    end else begin
      chk("rr_counts", {g_ids.size(), r_ids.size()}, {32'd4, 32'd4});
    end

    // Zero from requester 0: one grant pulse, latency DATA_W+1.
    clear_logs();
    set_lane(0, 0);
    req_valid[0] = 1'b1;
    wait_results(1, 100);
    run_cycles(2);
    chk("zero_grants", g_ids.size(), 1);
    if (g_ids.size() == 1 && r_ids.size() == 1) begin
      chk("zero_gid", g_ids[0], 0);
      chk("zero_latency", r_cyc[0] - g_cyc[0], DATA_W + 1);
      chk("zero_digits", r_dig[0], 0);
      chk("zero_id", r_ids[0], 0);
    end

    // Max value from requester 2.
    clear_logs();
    set_lane(2, 32'hFFFF_FFFF);
    req_valid[2] = 1'b1;
    wait_results(1, 100);
    run_cycles(2);
    if (r_ids.size() == 1) begin
      chk("max_digits", r_dig[0], 40'h4294967295);
      chk("max_id", r_ids[0], 2);
    end

    // Back-pressure: result held while res_ready low, no new grant.
    clear_logs();
    res_ready = 1'b0;
    set_lane(1, 99999);
    req_valid[1] = 1'b1;
    wait_results(1, 100);
    set_lane(3, 7);
    req_valid[3] = 1'b1;
    run_cycles(10);
    chk("bp_grants", g_ids.size(), 1);
    chk("bp_digits", res_digits, 40'h99999);
    chk("bp_busy", busy, 1);
    chk("bp_valid", res_valid, 1);
    res_ready = 1'b1;
    wait_results(2, 100);
    run_cycles(2);
    if (r_ids.size() == 2) begin
      chk("bp_next_id", r_ids[1], 3);
      chk("bp_next_dig", r_dig[1], 40'h7);
    end

    // Reset during conversion aborts the job and returns the pointer to 0.
    clear_logs();
    set_lane(3, 1000);
    req_valid[3] = 1'b1;
    wait_grants(1, 20);
    run_cycles(15);
    reset = 1'b1;
    run_cycles(1);
    reset = 1'b0;
    run_cycles(40);
    chk("abort_results", r_ids.size(), 0);
    chk("abort_valid", res_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_digits", res_digits, 0);
    chk("abort_id", res_id, 0);
    clear_logs();
    set_lane(1, 5); set_lane(3, 6);
    req_valid[1] = 1'b1;
    req_valid[3] = 1'b1;
    wait_results(2, 200);
    run_cycles(2);
    if (g_ids.size() == 2) chk("abort_first_gid", g_ids[0], 1);

    // Pointer wrap: after a grant to 3, requester 0 beats requester 3.
    clear_logs();
    set_lane(3, 1234);
    req_valid[3] = 1'b1;
    wait_results(1, 100);
    set_lane(0, 42);
    req_valid[0] = 1'b1;
    req_valid[3] = 1'b1;
    wait_results(3, 200);
    run_cycles(2);
    if (g_ids.size() == 3 && r_ids.size() == 3) begin
      chk("wrap_order", {g_ids[2][7:0], g_ids[1][7:0], g_ids[0][7:0]}, 64'h030003);
      chk("wrap_dig0", r_dig[0], 40'h1234);
      chk("wrap_dig1", r_dig[1], 40'h42);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
